// File: rtl/roberts_edge_pipe.sv
// roberts_edge_pipe
//   Pipelined Roberts-cross edge stage for the VGA display path. Pixels
//   arrive in raster order from the frame-memory read port. One previous
//   scan line is held in an internal line buffer. Each active pixel yields
//   a gradient magnitude G = |P(r-1,c-1)-P(r,c)| + |P(r-1,c)-P(r,c-1)|
//   and a thresholded edge bit. Latency is fixed at two clocks.
//
// Ports
//   vga_clk     pixel clock (sole clock)
//   reset       asynchronous, active-high reset
//   frame_start one-cycle pulse before the first active pixel of a frame
//   pix_valid   pix_in is an active pixel
//   pix_in      greyscale pixel, PIX_W bits
//   thresh      edge threshold, sampled in stage 2
//   grad_out    gradient magnitude, PIX_W+1 bits (0 on row 0 / column 0)
//   edge_out    grad_out > thresh (strict)
//   out_valid   pix_valid delayed by two clocks
//   out_col     column index of the pixel on grad_out
module roberts_edge_pipe #(
   parameter int H_ACTIVE = 640,
   parameter int PIX_W    = 4
) (
   input  logic             vga_clk,
   input  logic             reset,
   input  logic             frame_start,
   input  logic             pix_valid,
   input  logic [PIX_W-1:0] pix_in,
   input  logic [PIX_W-1:0] thresh,
   output logic [PIX_W:0]   grad_out,
   output logic             edge_out,
   output logic             out_valid,
   output logic [9:0]       out_col
);

   localparam int COL_W = 10;

   // Column / first-row tracking
   logic [COL_W-1:0] col_reg, col_next;
   logic             first_row_reg, first_row_next;
   // Column and first-row flag that apply to the pixel presented this
   // cycle. A coincident frame_start takes priority over the running
   // counter, so that pixel becomes column 0 of row 0.
   logic [COL_W-1:0] cur_col;
   logic             cur_first;

   always_comb begin
      cur_col        = frame_start ? '0 : col_reg;
      cur_first      = frame_start ? 1'b1 : first_row_reg;
      col_next       = cur_col;
      first_row_next = cur_first;
      if (pix_valid) begin
         if (cur_col == COL_W'(H_ACTIVE - 1)) begin
            col_next       = '0;
            first_row_next = 1'b0;
         end else begin
            col_next = cur_col + COL_W'(1);
         end
      end
   end

   // Line buffer. Read-before-write on the same column address, so up_reg
   // receives the pixel from the row above. The read register carries no
   // reset, which keeps it mappable onto block RAM. Its contents after reset
   // are never observed because first_row masks the whole first line.
   logic [PIX_W-1:0] line_mem [H_ACTIVE];
   logic [PIX_W-1:0] up_reg;

   always_ff @(posedge vga_clk) begin
      if (pix_valid) begin
         up_reg           <= line_mem[cur_col];
         line_mem[cur_col] <= pix_in;
      end
   end

   // Stage 1 registers
   logic [PIX_W-1:0] cur_reg, left_reg, upleft_reg;
   logic [COL_W-1:0] col_s1_reg;
   logic             first_s1_reg, valid_s1_reg;

   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         col_reg       <= '0;
         first_row_reg <= 1'b1;
         cur_reg       <= '0;
         left_reg      <= '0;
         upleft_reg    <= '0;
         col_s1_reg    <= '0;
         first_s1_reg  <= 1'b1;
         valid_s1_reg  <= 1'b0;
      end else begin
         col_reg       <= col_next;
         first_row_reg <= first_row_next;
         valid_s1_reg  <= pix_valid;
         if (pix_valid) begin
            cur_reg      <= pix_in;
            col_s1_reg   <= cur_col;
            first_s1_reg <= cur_first;
         end
         // The outgoing cur/up become the left-hand neighbours. up_reg is
         // updated on this same edge, so here it still holds P(r-1,c-1).
         if (frame_start) begin
            left_reg   <= '0;
            upleft_reg <= '0;
         end else if (pix_valid) begin
            left_reg   <= cur_reg;
            upleft_reg <= up_reg;
         end
      end
   end

   // Stage 2: the two diagonal absolute differences
   logic [PIX_W-1:0] diff_a [2];
   logic [PIX_W-1:0] diff_b [2];
   logic [PIX_W-1:0] absdiff [2];

   assign diff_a[0] = upleft_reg;
   assign diff_b[0] = cur_reg;
   assign diff_a[1] = up_reg;
   assign diff_b[1] = left_reg;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_absdiff
         assign absdiff[gi] = (diff_a[gi] >= diff_b[gi]) ? (diff_a[gi] - diff_b[gi])
                                                         : (diff_b[gi] - diff_a[gi]);
      end
   endgenerate

   logic [PIX_W:0] grad_next;
   logic           edge_next;

   always_comb begin
      grad_next = '0;
      if (valid_s1_reg && !first_s1_reg && (col_s1_reg != '0))
         grad_next = {1'b0, absdiff[0]} + {1'b0, absdiff[1]};
      edge_next = grad_next > {1'b0, thresh};
   end

   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         grad_out  <= '0;
         edge_out  <= 1'b0;
         out_valid <= 1'b0;
         out_col   <= '0;
      end else begin
         grad_out  <= grad_next;
         edge_out  <= edge_next;
         out_valid <= valid_s1_reg;
         out_col   <= col_s1_reg;
      end
   end

endmodule

// File: tb/tb_roberts_edge_pipe.sv
module tb_roberts_edge_pipe;
   localparam int H = 640;

   logic       vga_clk     = 1'b0;
   logic       reset       = 1'b0;
   logic       frame_start = 1'b0;
   logic       pix_valid   = 1'b0;
   logic [3:0] pix_in      = '0;
   logic [3:0] thresh      = '0;
   logic [4:0] grad_out;
   logic       edge_out;
   logic       out_valid;
   logic [9:0] out_col;

   roberts_edge_pipe #(.H_ACTIVE(H), .PIX_W(4)) dut (
      .vga_clk    (vga_clk),
      .reset      (reset),
      .frame_start(frame_start),
      .pix_valid  (pix_valid),
      .pix_in     (pix_in),
      .thresh     (thresh),
      .grad_out   (grad_out),
      .edge_out   (edge_out),
      .out_valid  (out_valid),
      .out_col    (out_col)
   );

   always #5 vga_clk = ~vga_clk;

   int checks = 0;
   int errors = 0;

   // Reference model: image-level view. Rows/columns are counted from the
   // stream; G is computed straight from the Roberts-cross definition.
   typedef struct { bit v; int row; int col; int g; bit e; } exp_t;
   exp_t pipe0, pipe1;
   int   m_row, m_col;
   int   prev_row [H];
   int   cur_row  [H];
   int   cap_g [4][H];
   int   cap_e [4][H];

   typedef struct { int pat; int row; int col; int g; bit e; } probe_t;
   probe_t probes [18];

   function automatic int absd(input int a, input int b);
      return (a > b) ? a - b : b - a;
   endfunction

   function automatic exp_t idle_exp();
      exp_t n;
      n.v = 1'b0; n.row = 0; n.col = 0; n.g = 0; n.e = 1'b0;
      return n;
   endfunction

   task automatic check_eq(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic check_out();
      if (pipe1.v) begin
         check_eq("out_valid", int'(out_valid), 1);
         check_eq("grad_out", int'(grad_out), pipe1.g);
         check_eq("edge_out", int'(edge_out), int'(pipe1.e));
         check_eq("out_col", int'(out_col), pipe1.col);
         if (pipe1.row < 4) begin
            cap_g[pipe1.row][pipe1.col] = int'(grad_out);
            cap_e[pipe1.row][pipe1.col] = int'(edge_out);
         end
      end else begin
         check_eq("idle_valid", int'(out_valid), 0);
         check_eq("idle_grad", int'(grad_out), 0);
         check_eq("idle_edge", int'(edge_out), 0);
      end
   endtask

   // One clock: check what is on the outputs now, then present new inputs.
   task automatic beat(input bit fs, input bit v, input int p);
      exp_t n;
      @(negedge vga_clk);
      check_out();
      n = idle_exp();
      if (fs) begin
         m_row = 0;
         m_col = 0;
      end
      if (v) begin
         n.v = 1'b1; n.row = m_row; n.col = m_col;
         cur_row[m_col] = p;
         if (m_row == 0 || m_col == 0) n.g = 0;
         else n.g = absd(prev_row[m_col-1], p) + absd(prev_row[m_col], cur_row[m_col-1]);
         n.e = (n.g > int'(thresh));
         m_col++;
         if (m_col == H) begin
            m_col = 0;
            m_row++;
            prev_row = cur_row;
         end
      end
      pipe1 = pipe0;
      pipe0 = n;
      frame_start = fs;
      pix_valid   = v;
      pix_in      = 4'(p);
   endtask

   // Clock under reset: the DUT ignores its inputs, so the model does too.
   task automatic reset_beat();
      @(negedge vga_clk);
      check_out();
      pipe1 = pipe0;
      pipe0 = idle_exp();
   endtask

   function automatic int pix_of(input int pat, input int r, input int c);
      case (pat)
         0:       return 7;
         1, 5:    return (c < 100) ? 0 : 15;
         2:       return (r == 1 && c == 50) ? 15 : 0;
         default: return int'($urandom_range(0, 15));
      endcase
   endfunction

   task automatic clear_capture();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < H; c++) begin
            cap_g[r][c] = -1;
            cap_e[r][c] = -1;
         end
   endtask

   task automatic flush();
      repeat (3) beat(1'b0, 1'b0, 0);
   endtask

   task automatic apply_probes(input int pat);
      for (int i = 0; i < 18; i++) begin
         if (probes[i].pat == pat) begin
            $display("probe pat=%0d r=%0d c=%0d g=%0d e=%0d",
                     pat, probes[i].row, probes[i].col,
                     cap_g[probes[i].row][probes[i].col], cap_e[probes[i].row][probes[i].col]);
            check_eq("probe_g", cap_g[probes[i].row][probes[i].col], probes[i].g);
            check_eq("probe_e", cap_e[probes[i].row][probes[i].col], int'(probes[i].e));
         end
      end
   endtask

   // Three-row frame of a fixed pattern; pattern 5 inserts blanking gaps.
   task automatic run_frame(input int pat, input logic [3:0] thr);
      thresh = thr;
      flush();
      clear_capture();
      beat(1'b1, 1'b0, 0);
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < H; c++) begin
            if (pat == 5 && (c == 200 || (r == 2 && c == 100)))
               repeat (5) beat(1'b0, 1'b0, 0);
            beat(1'b0, 1'b1, pix_of(pat, r, c));
         end
      flush();
      $display("frame pat=%0d thresh=%0d done", pat, thr);
      apply_probes(pat);
   endtask

   task automatic run_random(input int rows, input bit gaps);
      int n;
      thresh = 4'($urandom_range(0, 15));
      flush();
      beat(1'b1, 1'b0, 0);
      n = 0;
      while (n < rows * H) begin
         if (gaps && $urandom_range(0, 99) < 15) beat(1'b0, 1'b0, 0);
         else begin
            beat(1'b0, 1'b1, int'($urandom_range(0, 15)));
            n++;
         end
      end
      flush();
      $display("random frame rows=%0d thresh=%0d done", rows, thresh);
   endtask

   initial begin
      probes[0]  = '{0, 1, 5,   0,  1'b0};
      probes[1]  = '{0, 2, 639, 0,  1'b0};
      probes[2]  = '{1, 1, 100, 30, 1'b1};
      probes[3]  = '{1, 2, 100, 30, 1'b1};
      probes[4]  = '{1, 1, 99,  0,  1'b0};
      probes[5]  = '{1, 2, 101, 0,  1'b0};
      probes[6]  = '{1, 0, 100, 0,  1'b0};
      probes[7]  = '{1, 2, 0,   0,  1'b0};
      probes[8]  = '{2, 1, 50,  15, 1'b0};
      probes[9]  = '{2, 1, 51,  15, 1'b0};
      probes[10] = '{2, 2, 50,  15, 1'b0};
      probes[11] = '{2, 2, 51,  15, 1'b0};
      probes[12] = '{2, 1, 52,  0,  1'b0};
      probes[13] = '{2, 2, 49,  0,  1'b0};
      probes[14] = '{2, 0, 50,  0,  1'b0};
      probes[15] = '{5, 1, 200, 0,  1'b0};
      probes[16] = '{5, 2, 100, 30, 1'b1};
      probes[17] = '{4, 0, 0,   0,  1'b0};

      m_row = 0;
      m_col = 0;
      pipe0 = idle_exp();
      pipe1 = idle_exp();
      for (int c = 0; c < H; c++) begin
         prev_row[c] = 0;
         cur_row[c]  = 0;
      end

      // Power-on reset
      #2 reset = 1'b1;
      #1;
      check_eq("por_col", int'(out_col), 0);
      repeat (3) reset_beat();
      @(negedge vga_clk);
      reset = 1'b0;
      $display("reset released");

      run_frame(0, 4'h0);   // flat
      run_frame(1, 4'hE);   // vertical step
      run_frame(2, 4'hF);   // single dot, strict compare
      run_frame(5, 4'hE);   // step with mid-line gaps

      // frame_start coincident with a valid pixel at column 300 of row 1
      thresh = 4'h3;
      flush();
      clear_capture();
      beat(1'b1, 1'b0, 0);
      for (int c = 0; c < H; c++) beat(1'b0, 1'b1, pix_of(3, 0, c));
      for (int c = 0; c < 300; c++) beat(1'b0, 1'b1, pix_of(3, 1, c));
      beat(1'b1, 1'b1, pix_of(3, 0, 0));
      for (int c = 1; c < 2 * H; c++) beat(1'b0, 1'b1, pix_of(3, 0, c));
      flush();
      $display("frame_start+pix_valid sequence done");
      apply_probes(4);

      // Randomized frames, some with blanking gaps; every row wraps 639 -> 0
      run_random(3, 1'b0);
      run_random(3, 1'b1);
      run_random(2, 1'b1);

      // Asynchronous reset mid-line with pix_valid high
      thresh = 4'h2;
      flush();
      beat(1'b1, 1'b0, 0);
      for (int c = 0; c < H + 320; c++) beat(1'b0, 1'b1, int'($urandom_range(0, 15)));
      #2 reset = 1'b1;
      #1;
      check_eq("rst_grad", int'(grad_out), 0);
      check_eq("rst_edge", int'(edge_out), 0);
      check_eq("rst_valid", int'(out_valid), 0);
      check_eq("rst_col", int'(out_col), 0);
      pipe0 = idle_exp();
      pipe1 = idle_exp();
      m_row = 0;
      m_col = 0;
      repeat (2) reset_beat();
      reset = 1'b0;
      pix_valid = 1'b0;
      $display("mid-line reset released");
      for (int c = 0; c < 2 * H + 5; c++) beat(1'b0, 1'b1, int'($urandom_range(1, 15)));
      flush();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
